run_seq_ctrl: RTL
=================

RUN_SEQ_CTRL -- requirements
Module: run_seq_ctrl

Interface
REQ-001 The block SHALL have parameter MAG_W, default 30, as the operand/result magnitude width.
REQ-002 The block SHALL have parameter RST_CYC, default 16, as the number of clock cycles cpu_rst is held in LOAD.
REQ-003 The block SHALL have parameter TMO_CYC, default 1048576, as the RUN timeout in clock cycles.
REQ-004 The block SHALL have port clock, input, 1, the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port go, input, 1, raw start button level, already debounced.
REQ-007 The block SHALL have ports op_sign (input, 1) and op_mag (input, MAG_W), the operand from the input stage.
REQ-008 The block SHALL have ports cpu_rst (output, 1), cpu_sign (output, 1) and cpu_mag (output, MAG_W), which drive the CPU core.
REQ-009 The block SHALL have ports cpu_done (input, 1) and res_sign/res_mag (input, 1/MAG_W): a CPU completion level and the CPU result.
REQ-010 The block SHALL have ports conv_start (output, 1) and conv_done (input, 1): a pulse to the binary-to-BCD converter and its completion pulse.
REQ-011 The block SHALL have ports disp_valid (output, 1), disp_sign (output, 1) and disp_mag (output, MAG_W), the result latched for display.
REQ-012 The block SHALL have ports busy (output, 1) and err_tmo (output, 1).

Function
REQ-013 go SHALL be rising-edge detected; a start event is go=1 with the previous sample go=0.
REQ-014 cpu_done SHALL pass through a two-flop synchronizer before use, because the CPU runs on a divided clock.
REQ-015 The FSM SHALL have the states IDLE, LOAD, RUN, CONV, SHOW and ERR.
REQ-016 In IDLE, SHOW or ERR, a start event SHALL latch op_sign/op_mag into cpu_sign/cpu_mag, clear disp_valid and err_tmo, and enter LOAD.
REQ-017 In LOAD, cpu_rst SHALL be 1 for exactly RST_CYC cycles; the FSM then enters RUN with cpu_rst=0.
REQ-018 In RUN, the synchronized cpu_done=1 SHALL capture res_sign/res_mag into internal registers and enter CONV.
REQ-019 In RUN, if the cycle count reaches TMO_CYC without done, the FSM SHALL enter ERR, set err_tmo=1 and assert cpu_rst=1.
REQ-020 If done and timeout occur in the same cycle, done SHALL win.
REQ-021 On CONV entry, conv_start SHALL be a single-cycle pulse; conv_done SHALL be ignored in the pulse cycle and accepted from the following cycle.
REQ-022 On conv_done in CONV, the FSM SHALL copy the captured result to disp_sign/disp_mag, set disp_valid=1 and enter SHOW.
REQ-023 In SHOW, disp_* SHALL hold stable until the next start event.
REQ-024 busy SHALL be 1 in LOAD, RUN and CONV, and 0 otherwise.
REQ-025 Start events SHALL be ignored while busy=1.
REQ-026 cpu_sign/cpu_mag SHALL remain constant from LOAD entry until the next accepted start.
REQ-027 Counters SHALL be sized with clog2 of the larger of RST_CYC and TMO_CYC, plus 1; they SHALL saturate and never wrap.
REQ-028 The latency from the start edge to cpu_rst deassertion SHALL be RST_CYC+1 cycles.

Reset
REQ-029 On rst=1, the FSM SHALL go to IDLE.
REQ-030 On rst=1, cpu_rst SHALL be 1, and remain 1 in IDLE.
REQ-031 On rst=1, cpu_sign, cpu_mag, disp_sign, disp_mag, disp_valid, conv_start, busy and err_tmo SHALL be 0.
REQ-032 On rst=1, the synchronizer, the edge-detect register and all counters SHALL be 0.
REQ-033 Reset asserted mid-operation in any state SHALL abort with the same values on the next clock edge.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding and the default values of MAG_W, RST_CYC and TMO_CYC.
REQ-035 The synchronizer plus edge detector SHALL be a single sub-module, sync_edge, instantiated for both go and cpu_done.

Verification
REQ-036 Reset released, go pulse with op=+1234, cpu_done 40 cycles later, conv_done 35 cycles after conv_start -> cpu_rst high for 16 cycles, conv_start is one pulse, disp_valid=1, disp_mag=res_mag, busy=0.
REQ-037 cpu_done never asserted, TMO_CYC overridden to 100 -> ERR after 100 RUN cycles, err_tmo=1, cpu_rst=1, disp_valid=0.
REQ-038 Second go pulse during RUN -> ignored, cpu_mag unchanged; a go pulse in SHOW -> new run with disp_valid cleared.
REQ-039 cpu_done rising on the same cycle the timeout counter hits its limit -> enters CONV, err_tmo stays 0.
REQ-040 rst asserted for 1 cycle during CONV -> IDLE next cycle, all outputs at their reset values, and a late conv_done is ignored.
REQ-041 conv_done held high across conv_start -> SHOW is entered no earlier than one cycle after the conv_start pulse.

Source files
------------

// File: rtl/run_seq_ctrl_pkg.sv
// rtl/run_seq_ctrl_pkg.sv - shared state encoding and parameter defaults for run_seq_ctrl
package run_seq_ctrl_pkg;

  localparam int MAG_W_DEF   = 30;
  localparam int RST_CYC_DEF = 16;
  localparam int TMO_CYC_DEF = 1048576;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_CONV = 3'd3,
    ST_SHOW = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

  // One spare bit above the larger limit so a saturated count never aliases a limit.
  function automatic int cnt_width(input int a, input int b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/run_seq_ctrl_sync_edge.sv
// rtl/run_seq_ctrl_sync_edge.sv - optional flop synchronizer followed by a rising-edge detector
module sync_edge #(
  parameter int STAGES    = 2,
  parameter bit RISE_ONLY = 1'b0
) (
  input  logic clock,
  input  logic rst,
  input  logic din,
  output logic q
);

  logic level;
  logic prev;

  generate
    if (STAGES == 0) begin : g_direct
      assign level = din;
    end else begin : g_sync
      logic [STAGES-1:0] sync_q;

      always_ff @(posedge clock) begin
        if (rst) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= din;
          for (int i = 1; i < STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end

      assign level = sync_q[STAGES-1];
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (rst) begin
      prev <= 1'b0;
    end else begin
      prev <= level;
    end
  end

  // Edge mode for the start button, level mode for the CPU completion flag.
  assign q = RISE_ONLY ? (level & ~prev) : level;

endmodule

// File: rtl/run_seq_ctrl.sv
// rtl/run_seq_ctrl.sv - start/run/convert/show sequencer wrapped around the CPU core
module run_seq_ctrl
  import run_seq_ctrl_pkg::*;
#(
  parameter int MAG_W   = MAG_W_DEF,
  parameter int RST_CYC = RST_CYC_DEF,
  parameter int TMO_CYC = TMO_CYC_DEF
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             go,
  input  logic             op_sign,
  input  logic [MAG_W-1:0] op_mag,
  output logic             cpu_rst,
  output logic             cpu_sign,
  output logic [MAG_W-1:0] cpu_mag,
  input  logic             cpu_done,
  input  logic             res_sign,
  input  logic [MAG_W-1:0] res_mag,
  output logic             conv_start,
  input  logic             conv_done,
  output logic             disp_valid,
  output logic             disp_sign,
  output logic [MAG_W-1:0] disp_mag,
  output logic             busy,
  output logic             err_tmo
);

  localparam int               CNT_W    = cnt_width(RST_CYC, TMO_CYC);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             start_evt;
  logic             done_lvl;
  logic             res_sign_q;
  logic [MAG_W-1:0] res_mag_q;

  sync_edge #(
    .STAGES   (0),
    .RISE_ONLY(1'b1)
  ) u_go_edge (
    .clock(clock),
    .rst  (rst),
    .din  (go),
    .q    (start_evt)
  );

  // The CPU runs from a divided clock, so its done level is resynchronized.
  sync_edge #(
    .STAGES   (2),
    .RISE_ONLY(1'b0)
  ) u_done_sync (
    .clock(clock),
    .rst  (rst),
    .din  (cpu_done),
    .q    (done_lvl)
  );

  always_ff @(posedge clock) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      cpu_rst    <= 1'b1;
      cpu_sign   <= 1'b0;
      cpu_mag    <= '0;
      res_sign_q <= 1'b0;
      res_mag_q  <= '0;
      conv_start <= 1'b0;
      disp_valid <= 1'b0;
      disp_sign  <= 1'b0;
      disp_mag   <= '0;
      busy       <= 1'b0;
      err_tmo    <= 1'b0;
    end else begin
      conv_start <= 1'b0;
      case (state)
        ST_IDLE, ST_SHOW, ST_ERR: begin
          if (start_evt) begin
            cpu_sign   <= op_sign;
            cpu_mag    <= op_mag;
            disp_valid <= 1'b0;
            err_tmo    <= 1'b0;
            cpu_rst    <= 1'b1;
            busy       <= 1'b1;
            cnt        <= '0;
            state      <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (cnt == RST_LAST) begin
            cnt     <= '0;
            cpu_rst <= 1'b0;
            state   <= ST_RUN;
          end else begin
            cnt <= (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
          end
        end
        ST_RUN: begin
          // Done is tested first so it wins over a timeout landing in the same cycle.
          if (done_lvl) begin
            res_sign_q <= res_sign;
            res_mag_q  <= res_mag;
            cpu_rst    <= 1'b1;
            conv_start <= 1'b1;
            cnt        <= '0;
            state      <= ST_CONV;
          end else if (cnt == TMO_LAST) begin
            err_tmo <= 1'b1;
            cpu_rst <= 1'b1;
            busy    <= 1'b0;
            state   <= ST_ERR;
          end else begin
            cnt <= (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
          end
        end
        ST_CONV: begin
          // conv_start is still high in the entry cycle, which masks a stale conv_done.
          if (!conv_start && conv_done) begin
            disp_sign  <= res_sign_q;
            disp_mag   <= res_mag_q;
            disp_valid <= 1'b1;
            busy       <= 1'b0;
            state      <= ST_SHOW;
          end
        end
        default: begin
          cpu_rst <= 1'b1;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
